// File: rtl/shift_arbiter_if.sv
// Request/grant/result bundle for one requester of the shared shifter.
// The master side drives the op and the arbiter (slave) returns the grant and the result.
interface shift_arbiter_if;
  logic        req;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        gnt;
  logic        vld;
  logic [31:0] res;

  modport master (output req, op, a, shamt, input  gnt, vld, res);
  modport slave  (input  req, op, a, shamt, output gnt, vld, res);
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a single 32-bit barrel shifter (sll/sra).
// Define SHIFT_ARB_ROTATE_EN to enable rotate-left on opcode 10; otherwise it behaves as reserved.
module shift_arbiter #(
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  shift_arbiter_if.slave rq0,
  shift_arbiter_if.slave rq1,
  output logic           busy
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROL = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  state_t      state, state_nxt;
  logic        lp;
  logic        gnt0, gnt1;
  op_t         op_q;
  logic [31:0] a_q;
  logic [4:0]  shamt_q;
  logic        id_q;
  logic [31:0] shift_res;
  logic [31:0] res0_q, res1_q;
  logic        vld0_q, vld1_q;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (rq0.req && (!rq1.req || lp)) gnt0 = 1'b1;
          else if (rq1.req)                gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: registered state is always updated with non-blocking assignments.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q    <= OP_SLL;
      a_q     <= '0;
      shamt_q <= '0;
      id_q    <= 1'b0;
      lp      <= ~FIRST_PRI;
    end else if (gnt0 || gnt1) begin
      op_q    <= gnt1 ? op_t'(rq1.op) : op_t'(rq0.op);
      a_q     <= gnt1 ? rq1.a     : rq0.a;
      shamt_q <= gnt1 ? rq1.shamt : rq0.shamt;
      id_q    <= gnt1;
      lp      <= gnt1;
    end
  end

  // The only shifter instance; it sees the captured operands during EXEC.
  always_comb begin
    shift_res = '0;
    case (op_q)
      OP_SLL:  shift_res = a_q << shamt_q;
      OP_SRA:  shift_res = $unsigned($signed(a_q) >>> shamt_q);
`ifdef SHIFT_ARB_ROTATE_EN
      // A right shift by 32 yields zero, so shamt 0 returns a unchanged.
      OP_ROL:  shift_res = (a_q << shamt_q) | (a_q >> (6'd32 - {1'b0, shamt_q}));
`endif
      default: shift_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res0_q <= '0;
      res1_q <= '0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      if (state == EXEC) begin
        if (id_q) begin
          res1_q <= shift_res;
          vld1_q <= 1'b1;
        end else begin
          res0_q <= shift_res;
          vld0_q <= 1'b1;
        end
      end
    end
  end

  assign rq0.gnt = gnt0;
  assign rq1.gnt = gnt1;
  assign rq0.vld = vld0_q;
  assign rq1.vld = vld1_q;
  assign rq0.res = res0_q;
  assign rq1.res = res1_q;
  assign busy    = (state == EXEC);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases with literal results plus a
// randomized phase compared every cycle against a transaction-level reference model.
module tb_shift_arbiter;

  localparam bit FIRST_PRI = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
  localparam logic [31:0] ROL_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] ROL_EXP = 32'h0000_0000;
`endif

  logic clock = 1'b0;
  logic reset;
  logic busy;

  shift_arbiter_if rq0 ();
  shift_arbiter_if rq1 ();

  shift_arbiter #(.FIRST_PRI(FIRST_PRI)) dut (
    .clock (clock),
    .reset (reset),
    .rq0   (rq0),
    .rq1   (rq1),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from the shift rules written as plain arithmetic.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] sh);
    logic [63:0] w;
    logic [31:0] r;
    r = 32'h0;
    case (op)
      2'd0: begin
        w = {32'h0, a} * (64'd1 << sh);
        r = w[31:0];
      end
      2'd1: r = a[31] ? ~((~a) >> sh) : (a >> sh);
`ifdef SHIFT_ARB_ROTATE_EN
      2'd2: begin
        w = {a, a} << sh;
        r = w[63:32];
      end
`endif
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic get_req(input int id);
    return (id == 0) ? rq0.req : rq1.req;
  endfunction
  function automatic logic get_gnt(input int id);
    return (id == 0) ? rq0.gnt : rq1.gnt;
  endfunction
  function automatic logic get_vld(input int id);
    return (id == 0) ? rq0.vld : rq1.vld;
  endfunction
  function automatic logic [31:0] get_res(input int id);
    return (id == 0) ? rq0.res : rq1.res;
  endfunction

  task automatic drive(input int id, input logic rq, input logic [1:0] op,
                       input logic [31:0] a, input logic [4:0] sh);
    if (id == 0) begin
      rq0.req = rq; rq0.op = op; rq0.a = a; rq0.shamt = sh;
    end else begin
      rq1.req = rq; rq1.op = op; rq1.a = a; rq1.shamt = sh;
    end
  endtask

  function automatic logic [4:0] rand_sh();
    int unsigned k;
    k = $urandom_range(3, 0);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd31;
    return 5'($urandom_range(31, 0));
  endfunction

  task automatic new_op(input int id);
    drive(id, 1'b1, 2'($urandom_range(3, 0)), $urandom, rand_sh());
  endtask

  // Transaction-level model: each accepted op is stamped with the cycle its grant was
  // seen; busy is expected one cycle later and the result two cycles later.
  typedef struct {
    int          id;
    logic [31:0] r;
    int          g;
  } txn_t;

  txn_t        q[$];
  int          cyc;
  logic        lp_m;
  logic [31:0] res_m [2];

  always @(negedge clock) begin : model
    logic       busy_e;
    logic [1:0] vld_e, gnt_e;
    int         w;
    if (reset) begin
      q.delete();
      cyc      = 0;
      lp_m     = ~FIRST_PRI;
      res_m[0] = 32'h0;
      res_m[1] = 32'h0;
    end else begin
      cyc++;
      vld_e = 2'b00;
      gnt_e = 2'b00;
      if (q.size() > 0 && q[0].g + 2 == cyc) begin
        vld_e[q[0].id]  = 1'b1;
        res_m[q[0].id]  = q[0].r;
        void'(q.pop_front());
      end
      busy_e = (q.size() > 0 && q[0].g + 1 == cyc);
      if (!busy_e) begin
        w = -1;
        if (rq0.req && rq1.req) w = lp_m ? 0 : 1;
        else if (rq0.req)       w = 0;
        else if (rq1.req)       w = 1;
        if (w >= 0) begin
          gnt_e[w] = 1'b1;
          if (w == 0) q.push_back('{id: 0, r: ref_shift(rq0.op, rq0.a, rq0.shamt), g: cyc});
          else        q.push_back('{id: 1, r: ref_shift(rq1.op, rq1.a, rq1.shamt), g: cyc});
          lp_m = (w == 1);
        end
      end
      check("m_gnt0", {31'h0, rq0.gnt}, {31'h0, gnt_e[0]});
      check("m_gnt1", {31'h0, rq1.gnt}, {31'h0, gnt_e[1]});
      check("m_busy", {31'h0, busy},    {31'h0, busy_e});
      check("m_vld0", {31'h0, rq0.vld}, {31'h0, vld_e[0]});
      check("m_vld1", {31'h0, rq1.vld}, {31'h0, vld_e[1]});
      check("m_res0", rq0.res, res_m[0]);
      check("m_res1", rq1.res, res_m[1]);
    end
  end

  // One op through the handshake with exact cycle-by-cycle literal expectations.
  task automatic run_op(input string nm, input int id, input logic [1:0] op,
                        input logic [31:0] a, input logic [4:0] sh, input logic [31:0] exp);
    logic got;
    got = 1'b0;
    drive(id, 1'b1, op, a, sh);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = get_gnt(id);
    end
    check({nm, "_gnt"}, {31'h0, got}, 32'h1);
    @(posedge clock);
    #1;
    drive(id, 1'b0, op, a, sh);
    @(negedge clock);
    check({nm, "_busy"}, {31'h0, busy}, 32'h1);
    check({nm, "_early_vld"}, {31'h0, get_vld(id)}, 32'h0);
    @(negedge clock);
    check({nm, "_vld"}, {31'h0, get_vld(id)}, 32'h1);
    check({nm, "_other_vld"}, {31'h0, get_vld(1 - id)}, 32'h0);
    check({nm, "_res"}, get_res(id), exp);
    check({nm, "_busy_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin : main
    int   gid[$], gcyc[$];
    logic g0, g1, got;
    int   wait_c [2];

    reset = 1'b1;
    drive(0, 1'b1, 2'b00, 32'h1, 5'd1);
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    #12;
    check("rst_gnt0", {31'h0, rq0.gnt}, 32'h0);
    check("rst_busy", {31'h0, busy},    32'h0);
    check("rst_vld",  {30'h0, rq0.vld, rq1.vld}, 32'h0);
    check("rst_res0", rq0.res, 32'h0);
    check("rst_res1", rq1.res, 32'h0);
    drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_op("single_sll", 0, 2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780);
    run_op("sra31",      1, 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("sra1",       1, 2'b01, 32'h7FFF_FFFF, 5'd1,  32'h3FFF_FFFF);
    run_op("sll31",      0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("sll0",       1, 2'b00, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF);
    run_op("reserved",   0, 2'b11, 32'hA5A5_A5A5, 5'd7,  32'h0000_0000);
    run_op("rol",        1, 2'b10, 32'h8000_0001, 5'd1,  ROL_EXP);

    // Reset during EXEC drops the in-flight op.
    got = 1'b0;
    drive(0, 1'b1, 2'b00, 32'hDEAD_BEEF, 5'd3);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = rq0.gnt;
    end
    check("midrst_gnt", {31'h0, got}, 32'h1);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_gnt",  {30'h0, rq0.gnt, rq1.gnt}, 32'h0);
    check("midrst_vld",  {30'h0, rq0.vld, rq1.vld}, 32'h0);
    check("midrst_res0", rq0.res, 32'h0);
    check("midrst_res1", rq1.res, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("postrst_vld", {30'h0, rq0.vld, rq1.vld}, 32'h0);
    end

    // Continuous contention straight after reset: 0 first, then strict alternation.
    @(posedge clock);
    #1;
    new_op(0);
    new_op(1);
    for (int k = 0; k < 40 && gid.size() < 6; k++) begin
      @(negedge clock);
      g0 = rq0.gnt;
      g1 = rq1.gnt;
      if (g0) begin gid.push_back(0); gcyc.push_back(k); end
      if (g1) begin gid.push_back(1); gcyc.push_back(k); end
      @(posedge clock);
      #1;
      if (g0) new_op(0);
      if (g1) new_op(1);
    end
    check("cont_count", gid.size(), 32'd6);
    check("cont_first_cycle", (gcyc.size() > 0) ? gcyc[0] : -1, 32'd0);
    for (int i = 0; i < gid.size(); i++) begin
      check("cont_order", gid[i], i % 2);
      if (i > 0) check("cont_spacing", gcyc[i] - gcyc[i-1], 32'd2);
    end
    drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (3) @(negedge clock);

    // Randomized traffic; the model process checks every cycle.
    wait_c[0] = 0;
    wait_c[1] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      g0 = rq0.gnt;
      g1 = rq1.gnt;
      if (rq0.req && !g0) wait_c[0]++;
      if (rq1.req && !g1) wait_c[1]++;
      @(posedge clock);
      #1;
      for (int id = 0; id < 2; id++) begin
        if ((id == 0) ? g0 : g1) begin
          check("wait_bound", {31'h0, (wait_c[id] <= 4)}, 32'h1);
          wait_c[id] = 0;
          if ($urandom_range(1, 0) == 1) new_op(id);
          else drive(id, 1'b0, 2'b00, 32'h0, 5'd0);
        end else if (!get_req(id) && $urandom_range(3, 0) == 0) begin
          new_op(id);
        end
      end
    end
    drive(0, 1'b0, 2'b00, 32'h0, 5'd0);
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath between two requesters (for example, the execute stage and the multdiv unit).
- Shift ops supported: logical-left and arithmetic-right barrel shifts.
- Round-robin arbitration with a request/grant handshake.
- Operands are captured into a register and the result is registered, so each op takes 2 cycles.
- Sits beside the ALU in the CPU datapath. It owns the only shifter instance.

Parameters:
- FIRST_PRI, default 0: the requester that wins the first tie after reset (0 or 1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0  in  1  requester 0 request; held high until gnt0 is sampled high
- op0  in  2  requester 0 opcode: 00 sll, 01 sra, 10 rol (feature-gated), 11 reserved
- a0  in  32  requester 0 operand
- shamt0  in  5  requester 0 shift amount, 0..31
- gnt0  out  1  combinational grant to requester 0
- vld0  out  1  one-cycle pulse: res0 is valid
- res0  out  32  requester 0 result
- req1, op1, a1, shamt1, gnt1, vld1, res1: same as requester 0, for requester 1
- busy  out  1  high while an op is in flight (state EXEC)

Behaviour:
- Reset values:
  - state = IDLE.
  - gnt0 = gnt1 = 0 (no requests are granted while reset is high).
  - vld0 = vld1 = 0; res0 = res1 = 32'h0; busy = 0.
  - Internal operand registers cleared.
  - Last-granted pointer lp = ~FIRST_PRI.
- State machine, two states:
  - IDLE: if any req is high, grant exactly one (combinationally). At the clock edge, capture {op, a, shamt, requester id}, set lp = granted id, go to EXEC. With no req, stay in IDLE.
  - EXEC: no grants. The shifter evaluates the captured operands. At the edge: load the result into res of the captured id, pulse that vld for the following cycle, go to IDLE.
- Arbitration:
  - Only one requester asserted: it wins.
  - Both asserted: the requester != lp wins, so strict alternation under continuous contention.
  - gnt is high only in IDLE, and only for the winner.
- Handshake:
  - The requester keeps req, op, a and shamt stable until the edge where its gnt is high.
  - After that edge it may drop req or present a new op; the new op is eligible at the next IDLE.
- Timing:
  - Accept at edge T; result registered at edge T+1; vld high during the cycle after T+1.
  - Throughput: one op every 2 cycles.
  - A new grant is allowed in the same cycle that vld is high.
- Results:
  - res0 and res1 hold their last value until overwritten by that requester's next op.
  - vld is high for exactly one cycle per op.
  - The other requester's res and vld are unaffected.
- Arithmetic:
  - sll: a << shamt, zero fill.
  - sra: a >>> shamt, filled with a[31].
  - shamt 0 returns a unchanged.
- Reserved opcode: the op is accepted normally; result 32'h0; vld still pulses.
- Reset mid-operation: the in-flight op is dropped, no vld is produced, and state returns to IDLE.
- Requests arriving during EXEC wait; nothing is lost as long as the requester holds req.

Optional Feature:
- Macro: SHIFT_ARB_ROTATE_EN.
- Defined: op 10 = rotate left, result = (a << shamt) | (a >> (32 - shamt)); shamt 0 returns a.
- Undefined: op 10 is treated as reserved (result 32'h0, vld still pulses).
- Op 11 is always reserved.

Test Plan:
- Single op. Reset, then req0=1, op0=00, a0=32'h12345678, shamt0=4.
  - gnt0=1 in the first IDLE cycle.
  - busy=1 for one cycle, then vld0=1 for one cycle with res0=32'h23456780.
  - vld1 stays 0.
- Arithmetic right. req1 only, op1=01, a1=32'h80000000, shamt1=31.
  - res1=32'hFFFFFFFF; vld1 pulses once.
  - Then a1=32'h7FFFFFFF, shamt1=1 gives res1=32'h3FFFFFFF.
- Contention. req0 and req1 held high continuously, FIRST_PRI=0.
  - Grant order 0, 1, 0, 1, with one grant every 2 cycles.
  - Each vld appears 2 edges after its grant edge; no req goes unserved for more than 4 cycles.
- Boundaries.
  - sll with a=32'h00000001, shamt=31 gives 32'h80000000.
  - sll with a=32'hFFFFFFFF, shamt=0 gives 32'hFFFFFFFF.
  - Reserved op 11 gives 32'h0 with vld pulsing.
- Reset mid-op. Assert reset during EXEC.
  - All outputs go to 0 immediately; no vld appears after reset is released.
  - The next req0 is granted first when FIRST_PRI=0.
- Feature.
  - With SHIFT_ARB_ROTATE_EN: op=10, a=32'h80000001, shamt=1 gives 32'h00000003.
  - Without it: the same stimulus gives 32'h0.
